// File: rtl/mem_pkg.sv
// Shared definitions for the stream-to-RAM writer: default widths,
// RAM depth and the controller state encoding.
package mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int RAM_DEPTH  = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FINISH = 2'd2,
      VERIFY = 2'd3
   } state_t;

endpackage

// File: rtl/mem_stream_writer_if.sv
// Byte stream handshake plus RAM write port, seen from the writer (master)
// and from the surrounding system (slave).
interface mem_stream_writer_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              i_s_valid;
   logic [DATA_W-1:0] i_s_data;
   logic              o_s_ready;
   logic              o_w_en;
   logic [ADDR_W-1:0] o_w_addr;
   logic [DATA_W-1:0] o_w_data;

   modport master (
      input  i_s_valid, i_s_data,
      output o_s_ready, o_w_en, o_w_addr, o_w_data
   );

   modport slave (
      output i_s_valid, i_s_data,
      input  o_s_ready, o_w_en, o_w_addr, o_w_data
   );
endinterface

// File: rtl/mem_readback_checker.sv
// Readback sequencer for the optional verify pass: issues one read per clock
// from the base address (wrapping) and sums the returned bytes, which arrive
// one clock after each read request.
module mem_readback_checker
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_length,
   output logic              o_r_en,
   output logic [ADDR_W-1:0] o_r_addr,
   input  logic [DATA_W-1:0] i_r_data,
   output logic              o_done,
   output logic [DATA_W-1:0] o_sum
);
   localparam logic [ADDR_W:0]   LEFT_ONE = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   logic              active_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   left_reg;
   logic              r_en_reg;
   logic [ADDR_W-1:0] r_addr_reg;
   logic              pend_reg;
   logic [DATA_W-1:0] sum_reg;
   logic              done_reg;

   // Read issue, latency-aligned accumulation and completion detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         active_reg <= 1'b0;
         addr_reg   <= '0;
         left_reg   <= '0;
         r_en_reg   <= 1'b0;
         r_addr_reg <= '0;
         pend_reg   <= 1'b0;
         sum_reg    <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (i_start) begin
            active_reg <= 1'b1;
            addr_reg   <= i_base_addr;
            left_reg   <= i_length;
            r_en_reg   <= 1'b0;
            pend_reg   <= 1'b0;
            sum_reg    <= '0;
         end else if (active_reg) begin
            if (left_reg != '0) begin
               r_en_reg   <= 1'b1;
               r_addr_reg <= addr_reg;
               addr_reg   <= addr_reg + ADDR_ONE;
               left_reg   <= left_reg - LEFT_ONE;
            end else begin
               r_en_reg <= 1'b0;
            end
            pend_reg <= r_en_reg;
            if (pend_reg) begin
               sum_reg <= sum_reg + i_r_data;
            end
            // Last data word is being summed: nothing left in flight.
            if (left_reg == '0 && !r_en_reg && pend_reg) begin
               done_reg   <= 1'b1;
               active_reg <= 1'b0;
            end
         end
      end
   end

   assign o_r_en   = r_en_reg;
   assign o_r_addr = r_addr_reg;
   assign o_done   = done_reg;
   assign o_sum    = sum_reg;
endmodule

// File: rtl/mem_stream_writer.sv
// Stream-to-RAM writer: accepts bytes on a valid/ready handshake and writes
// them to consecutive RAM addresses from a programmable base (wrapping).
// Optional readback checksum verification is enabled by defining
// MEM_STREAM_WRITER_VERIFY_EN.
module mem_stream_writer
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [ADDR_W-1:0]    i_base_addr,
   input  logic [ADDR_W:0]      i_length,
   mem_stream_writer_if.master  bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [ADDR_W:0]      o_count
`ifdef MEM_STREAM_WRITER_VERIFY_EN
   ,
   output logic                 o_r_en,
   output logic [ADDR_W-1:0]    o_r_addr,
   input  logic [DATA_W-1:0]    i_r_data,
   output logic                 o_err
`endif
);
   localparam logic [ADDR_W:0] CNT_ONE = 1;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W:0]   len_reg;
   logic [ADDR_W:0]   count_reg;
   logic              w_en_reg;
   logic [ADDR_W-1:0] w_addr_reg;
   logic [DATA_W-1:0] w_data_reg;
   logic              done_reg;
   logic              accept;
   logic              last_byte;

`ifdef MEM_STREAM_WRITER_VERIFY_EN
   logic [DATA_W-1:0] wsum_reg;
   logic              err_reg;
   logic              chk_done;
   logic [DATA_W-1:0] chk_sum;
`endif

   assign bus.o_s_ready = (state_reg == WRITE);
   assign accept        = bus.i_s_valid && (state_reg == WRITE);
   assign last_byte     = accept && ((count_reg + CNT_ONE) == len_reg);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a zero-length start never leaves IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (i_start && i_length != '0) state_next = WRITE;
         end
         WRITE: begin
`ifdef MEM_STREAM_WRITER_VERIFY_EN
            if (last_byte) state_next = VERIFY;
`else
            if (last_byte) state_next = FINISH;
`endif
         end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
         VERIFY: begin
            if (chk_done) state_next = FINISH;
         end
`endif
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transfer datapath: start latching, registered RAM writes, done pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         base_reg   <= '0;
         len_reg    <= '0;
         count_reg  <= '0;
         w_en_reg   <= 1'b0;
         w_addr_reg <= '0;
         w_data_reg <= '0;
         done_reg   <= 1'b0;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
         wsum_reg   <= '0;
         err_reg    <= 1'b0;
`endif
      end else begin
         w_en_reg <= 1'b0;
         // Done follows the FINISH cycle, or directly a zero-length start.
         done_reg <= (state_reg == FINISH);
         if (state_reg == IDLE && i_start) begin
            base_reg  <= i_base_addr;
            len_reg   <= i_length;
            count_reg <= '0;
            if (i_length == '0) done_reg <= 1'b1;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
            wsum_reg  <= '0;
            err_reg   <= 1'b0;
`endif
         end
         if (accept) begin
            w_en_reg   <= 1'b1;
            w_addr_reg <= base_reg + count_reg[ADDR_W-1:0];
            w_data_reg <= bus.i_s_data;
            count_reg  <= count_reg + CNT_ONE;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
            wsum_reg   <= wsum_reg + bus.i_s_data;
`endif
         end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
         if (chk_done) err_reg <= (chk_sum != wsum_reg);
`endif
      end
   end

   assign bus.o_w_en   = w_en_reg;
   assign bus.o_w_addr = w_addr_reg;
   assign bus.o_w_data = w_data_reg;
   assign o_done       = done_reg;
   assign o_count      = count_reg;

`ifdef MEM_STREAM_WRITER_VERIFY_EN
   assign o_busy = (state_reg == WRITE) || (state_reg == VERIFY);
   assign o_err  = err_reg;

   mem_readback_checker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_checker (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (last_byte),
      .i_base_addr (base_reg),
      .i_length    (len_reg),
      .o_r_en      (o_r_en),
      .o_r_addr    (o_r_addr),
      .i_r_data    (i_r_data),
      .o_done      (chk_done),
      .o_sum       (chk_sum)
   );
`else
   assign o_busy = (state_reg == WRITE);
`endif
endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: random byte streams against a reference
// memory image and expected write sequence derived from base/length rules.
module tb_mem_stream_writer;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] base_addr;
   logic [8:0] length;
   logic       busy;
   logic       done;
   logic [8:0] count;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
   logic       r_en;
   logic [7:0] r_addr;
   logic [7:0] r_data;
   logic       err;
`endif

   int errors = 0;
   int checks = 0;
   int done_events = 0;
   int corrupt_en = 0;
   logic [7:0] corrupt_addr = 8'h00;
   logic       ram_init;
   logic [7:0] ram [256];
   logic [7:0] exp_mem [256];
   logic [7:0] bytes [256];
   logic [15:0] obs_q [$];

   mem_stream_writer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mem_stream_writer #(.ADDR_W(8), .DATA_W(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_length    (length),
      .bus         (bus),
      .o_busy      (busy),
      .o_done      (done),
      .o_count     (count)
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      ,
      .o_r_en      (r_en),
      .o_r_addr    (r_addr),
      .i_r_data    (r_data),
      .o_err       (err)
`endif
   );

   always #5 clk = ~clk;

   // RAM model; an optional stuck location inverts the stored byte.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
      end else if (bus.o_w_en) begin
         ram[bus.o_w_addr] <= (corrupt_en != 0 && bus.o_w_addr == corrupt_addr) ?
                              ~bus.o_w_data : bus.o_w_data;
      end
   end

`ifdef MEM_STREAM_WRITER_VERIFY_EN
   // Registered RAM read port.
   always @(posedge clk) begin
      if (r_en) r_data <= ram[r_addr];
   end
`endif

   // Write-port and done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.o_w_en === 1'b1) obs_q.push_back({bus.o_w_addr, bus.o_w_data});
      if (done === 1'b1) done_events++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ram_init = 1'b1; start = 1'b0; base_addr = '0; length = '0;
      bus.i_s_valid = 1'b0; bus.i_s_data = '0;
      for (int k = 0; k < 256; k++) exp_mem[k] = 8'h00;
      tick; tick;
      ram_init = 1'b0;
      checks++; if (bus.o_w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got=%b want=0", bus.o_w_en); end
      checks++; if (bus.o_w_addr !== 8'h00) begin errors++; $display("FAIL reset_w_addr got=%h want=00", bus.o_w_addr); end
      checks++; if (bus.o_w_data !== 8'h00) begin errors++; $display("FAIL reset_w_data got=%h want=00", bus.o_w_data); end
      checks++; if ({busy, done, bus.o_s_ready} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {busy, done, bus.o_s_ready}); end
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
`endif
      rst = 1'b0;
      tick;
      $display("reset done");
   endtask

   // One transfer of bytes[0..len-1]; mode 0 = valid held, 1 = toggling,
   // 2 = random valid. ignore_at >= 0 pulses a stray start at that byte.
   task automatic run_transfer(input logic [7:0] b, input int len, input int mode, input int ignore_at);
      int i, cyc, wait_cyc, d0, bad;
      logic v;
      logic [7:0] a;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      logic [7:0] sum_w, sum_r;
      logic err_exp;
      sum_w = 8'h00; sum_r = 8'h00;
`endif
      obs_q.delete();
      d0 = done_events;
      for (int k = 0; k < len; k++) begin
         a = b + k[7:0];
         exp_mem[a] = (corrupt_en != 0 && a == corrupt_addr) ? ~bytes[k] : bytes[k];
`ifdef MEM_STREAM_WRITER_VERIFY_EN
         sum_w = sum_w + bytes[k];
`endif
      end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      for (int k = 0; k < len; k++) begin
         a = b + k[7:0];
         sum_r = sum_r + exp_mem[a];
      end
      err_exp = (sum_w != sum_r);
`endif
      start = 1'b1; base_addr = b; length = len[8:0];
      tick;
      start = 1'b0; base_addr = 8'($urandom); length = 9'($urandom);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b want=1", busy); end
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL start_count got=%0d want=0", count); end
      i = 0; cyc = 0;
      while (i < len && cyc < 3000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         if (i == ignore_at) begin
            start = 1'b1; base_addr = 8'($urandom); length = 9'($urandom_range(1, 5));
         end
         bus.i_s_valid = v;
         bus.i_s_data  = v ? bytes[i] : 8'($urandom);
         checks++; if (bus.o_s_ready !== 1'b1) begin errors++; $display("FAIL ready_in_write byte=%0d got=%b want=1", i, bus.o_s_ready); end
         tick;
         start = 1'b0;
         checks++; if (bus.o_w_en !== v) begin errors++; $display("FAIL w_en_timing byte=%0d got=%b want=%b", i, bus.o_w_en, v); end
         if (v) i++;
         cyc++;
      end
      bus.i_s_valid = 1'b0;
      checks++; if (i != len) begin errors++; $display("FAIL stream_timeout accepted=%0d want=%0d", i, len); end
      checks++; if (bus.o_s_ready !== 1'b0) begin errors++; $display("FAIL ready_after_last got=%b want=0", bus.o_s_ready); end
      tick;
      wait_cyc = 0;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      while (done !== 1'b1 && wait_cyc < 600) begin tick; wait_cyc++; end
`endif
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_timing got=%b want=1 waited=%0d", done, wait_cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b want=0", busy); end
      checks++; if (count !== len[8:0]) begin errors++; $display("FAIL done_count got=%0d want=%0d", count, len); end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      checks++; if (err !== err_exp) begin errors++; $display("FAIL verify_err got=%b want=%b", err, err_exp); end
`endif
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b want=0", done); end
      checks++; if (done_events - d0 != 1) begin errors++; $display("FAIL done_count_pulses got=%0d want=1", done_events - d0); end
      checks++; if (obs_q.size() != len) begin errors++; $display("FAIL write_count got=%0d want=%0d", obs_q.size(), len); end
      bad = 0;
      for (int k = 0; k < len && k < obs_q.size(); k++) begin
         a = b + k[7:0];
         if (obs_q[k] !== {a, bytes[k]}) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL write_sequence bad=%0d want=0 first=%h exp_first=%h", bad, obs_q[0], {b, bytes[0]}); end
      bad = 0;
      for (int k = 0; k < 256; k++) if (ram[k] !== exp_mem[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ram_image bad=%0d want=0", bad); end
      $display("xfer base=%h len=%0d mode=%0d writes=%0d", b, len, mode, obs_q.size());
   endtask

   task automatic test_single_byte;
      bytes[0] = 8'hA5;
      run_transfer(8'h00, 1, 0, -1);
   endtask

   task automatic test_streaming;
      for (int k = 0; k < 16; k++) bytes[k] = k[7:0];
      run_transfer(8'h10, 16, 0, -1);
   endtask

   task automatic test_wrap_bubbles;
      for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
      run_transfer(8'hF8, 16, 1, -1);
   endtask

   task automatic test_zero_length;
      int d0;
      obs_q.delete();
      d0 = done_events;
      start = 1'b1; base_addr = 8'h33; length = 9'd0;
      tick;
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_len_done got=%b want=1", done); end
      checks++; if ({busy, bus.o_s_ready, bus.o_w_en} !== 3'b000) begin errors++; $display("FAIL zero_len_flags got=%b want=000", {busy, bus.o_s_ready, bus.o_w_en}); end
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL zero_len_count got=%0d want=0", count); end
      tick; tick;
      checks++; if (done_events - d0 != 1) begin errors++; $display("FAIL zero_len_pulses got=%0d want=1", done_events - d0); end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_len_writes got=%0d want=0", obs_q.size()); end
      $display("xfer base=33 len=0 writes=%0d", obs_q.size());
   endtask

   task automatic test_ignored_start;
      int d0;
      for (int k = 0; k < 8; k++) bytes[k] = 8'($urandom);
      run_transfer(8'h40, 8, 0, 3);
      d0 = done_events;
      tick; tick; tick;
      checks++; if (busy !== 1'b0 || done_events != d0) begin errors++; $display("FAIL ignored_start_queued busy=%b pulses=%0d want busy=0 pulses=0", busy, done_events - d0); end
   endtask

   task automatic test_random;
      int len;
      logic [7:0] b;
      for (int t = 0; t < 4; t++) begin
         len = (t == 3) ? 256 : int'($urandom_range(1, 40));
         b = 8'($urandom);
         for (int k = 0; k < len; k++) bytes[k] = 8'($urandom);
         run_transfer(b, len, 2, -1);
      end
   endtask

   task automatic test_reset_mid_burst;
      int d0, bad;
      logic [7:0] a, b;
      b = 8'hC0;
      for (int k = 0; k < 10; k++) bytes[k] = 8'($urandom);
      for (int k = 0; k < 5; k++) begin a = b + k[7:0]; exp_mem[a] = bytes[k]; end
      obs_q.delete();
      d0 = done_events;
      start = 1'b1; base_addr = b; length = 9'd10;
      tick;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.i_s_valid = 1'b1; bus.i_s_data = bytes[k];
         tick;
      end
      bus.i_s_data = bytes[5];
      rst = 1'b1;
      tick;
      checks++; if (bus.o_w_en !== 1'b0) begin errors++; $display("FAIL rst_mid_w_en got=%b want=0", bus.o_w_en); end
      checks++; if ({busy, bus.o_s_ready, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got=%b want=000", {busy, bus.o_s_ready, done}); end
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL rst_mid_count got=%0d want=0", count); end
      tick;
      rst = 1'b0; bus.i_s_valid = 1'b0;
      tick; tick;
      checks++; if (done_events != d0) begin errors++; $display("FAIL rst_mid_done got=%0d want=0", done_events - d0); end
      checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL rst_mid_writes got=%0d want=5", obs_q.size()); end
      bad = 0;
      for (int k = 0; k < 256; k++) if (ram[k] !== exp_mem[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_ram bad=%0d want=0", bad); end
      $display("xfer base=%h len=10 reset after 5 writes=%0d", b, obs_q.size());
      for (int k = 0; k < 10; k++) bytes[k] = 8'($urandom);
      run_transfer(8'h05, 10, 0, -1);
   endtask

`ifdef MEM_STREAM_WRITER_VERIFY_EN
   task automatic test_verify;
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
      corrupt_en = 1; corrupt_addr = 8'h62;
      run_transfer(8'h60, 4, 0, -1);
      corrupt_en = 0;
      tick;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL verify_err_sticky got=%b want=1", err); end
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
      run_transfer(8'h60, 4, 2, -1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL verify_clean_err got=%b want=0", err); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_byte;
      test_streaming;
      test_wrap_bubbles;
      test_zero_length;
      test_ignored_start;
      test_random;
      test_reset_mid_burst;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
      test_verify;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
